// File: rtl/filter_preloader.sv
// filter_preloader: groups a serial weight stream into lane triplets and
// issues one preload write (shared address, three lane words) per triplet.
//
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   start               - begin a load (honoured only when idle)
//   abort               - cancel a load in progress
//   s_valid/s_ready     - stream handshake, s_data is the weight word
//   preload_en          - one-cycle write strobe to the filter buffer
//   preload_addr        - shared address for all three lanes
//   preload_data_pe0..2 - lane write data
//   busy                - load in progress (LOAD or FIN)
//   done                - one-cycle completion pulse
//   loaded_count        - triplets written in the current or last load
module filter_preloader #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_FILTERS  = 1,
  parameter int unsigned NUM_CHANNELS = 1,
  parameter int unsigned KERNEL_SIZE  = 3,
  localparam int unsigned DEPTH = NUM_FILTERS * NUM_CHANNELS * KERNEL_SIZE,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  preload_en,
  output logic [AW-1:0]         preload_addr,
  output logic [DATA_WIDTH-1:0] preload_data_pe0,
  output logic [DATA_WIDTH-1:0] preload_data_pe1,
  output logic [DATA_WIDTH-1:0] preload_data_pe2,
  output logic                  busy,
  output logic                  done,
  output logic [AW:0]           loaded_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t                state;
  logic [1:0]            lane;
  logic [AW-1:0]         addr_cnt;
  logic [DATA_WIDTH-1:0] hold_0;
  logic [DATA_WIDTH-1:0] hold_1;
  logic                  beat;

  // s_ready is only high in LOAD, so a handshake implies LOAD
  assign beat = s_valid && s_ready;

  // Load sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      lane             <= 2'd0;
      addr_cnt         <= '0;
      hold_0           <= '0;
      hold_1           <= '0;
      s_ready          <= 1'b0;
      preload_en       <= 1'b0;
      preload_addr     <= '0;
      preload_data_pe0 <= '0;
      preload_data_pe1 <= '0;
      preload_data_pe2 <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      loaded_count     <= '0;
    end else begin
      preload_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            s_ready      <= 1'b1;
            busy         <= 1'b1;
            lane         <= 2'd0;
            addr_cnt     <= '0;
            loaded_count <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            // Partial triplet is dropped; a beat arriving with abort is lost
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            lane    <= 2'd0;
          end else if (beat) begin
            case (lane)
              2'd0: begin
                hold_0 <= s_data;
                lane   <= 2'd1;
              end
              2'd1: begin
                hold_1 <= s_data;
                lane   <= 2'd2;
              end
              default: begin
                lane             <= 2'd0;
                preload_en       <= 1'b1;
                preload_addr     <= addr_cnt;
                preload_data_pe0 <= hold_0;
                preload_data_pe1 <= hold_1;
                preload_data_pe2 <= s_data;
                loaded_count     <= loaded_count + (AW + 1)'(1);
                // Stop at the last address instead of wrapping
                if (addr_cnt == LAST_ADDR) begin
                  state   <= FIN;
                  s_ready <= 1'b0;
                end else begin
                  addr_cnt <= addr_cnt + AW'(1);
                end
              end
            endcase
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_preloader.sv
// Testbench for filter_preloader: two configurations (DEPTH=12 and DEPTH=3)
// run side by side, each with a reference model feeding a write scoreboard.
module tb_filter_preloader;

  localparam int DW = 16;

  typedef struct {
    int addr;
    int d0;
    int d1;
    int d2;
    int due;
  } wr_t;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input int inst, input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL [cfg%0d] %s: got %0d, expected %0d (t=%0t)", inst, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NF = (g == 0) ? 2 : 1;
    localparam int NC = (g == 0) ? 2 : 1;
    localparam int K  = 3;
    localparam int D  = NF * NC * K;
    localparam int AW = $clog2(D);
    localparam int NB = 3 * D;

    logic          rst, start, abort, s_valid, s_ready, preload_en, busy, done;
    logic [DW-1:0] s_data, pd0, pd1, pd2;
    logic [AW-1:0] preload_addr;
    logic [AW:0]   loaded_count;

    filter_preloader #(
      .DATA_WIDTH(DW), .NUM_FILTERS(NF), .NUM_CHANNELS(NC), .KERNEL_SIZE(K)
    ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .preload_en(preload_en), .preload_addr(preload_addr),
      .preload_data_pe0(pd0), .preload_data_pe1(pd1), .preload_data_pe2(pd2),
      .busy(busy), .done(done), .loaded_count(loaded_count)
    );

    // Reference model: a load collects accepted words three at a time;
    // each full group becomes the next write, the load ends after D groups.
    int  cyc = 0;
    bit  loading = 0, finishing = 0, acc = 0;
    bit  exp_ready = 0, exp_busy = 0, exp_done = 0;
    int  groups = 0;
    int  held[$];
    wr_t expq[$];

    always @(posedge clk) begin : model
      cyc++;
      acc = 1'b0;
      if (rst) begin
        loading   = 1'b0;
        finishing = 1'b0;
        exp_done  = 1'b0;
        groups    = 0;
        held.delete();
      end else begin
        exp_done = finishing;
        if (finishing) begin
          finishing = 1'b0;
        end else if (loading) begin
          if (abort) begin
            loading = 1'b0;
            held.delete();
          end else if (s_valid) begin
            acc = 1'b1;
            held.push_back(int'(s_data));
            if (held.size() == 3) begin
              expq.push_back('{groups, held[0], held[1], held[2], cyc});
              groups++;
              held.delete();
              if (groups == D) begin
                loading   = 1'b0;
                finishing = 1'b1;
              end
            end
          end
        end else if (start) begin
          loading = 1'b1;
          groups  = 0;
          held.delete();
        end
      end
      exp_ready = loading;
      exp_busy  = loading || finishing;
    end

    // Monitor: pops expected writes when the DUT strobes, checks status every cycle
    int  last_a = 0, last_0 = 0, last_1 = 0, last_2 = 0;
    int  wr_cnt = 0, done_cnt = 0, done_cyc = -1;
    wr_t w;

    always @(posedge clk) begin : monitor
      #1;
      if (rst) begin
        last_a = 0; last_0 = 0; last_1 = 0; last_2 = 0;
      end
      if (preload_en) begin
        wr_cnt++;
        if (expq.size() == 0) begin
          chk(g, "unexpected_write", 1, 0);
        end else begin
          w = expq.pop_front();
          chk(g, "write_cycle", longint'(cyc), longint'(w.due));
          chk(g, "write_addr", longint'(preload_addr), longint'(w.addr));
          chk(g, "write_pe0", longint'(pd0), longint'(w.d0));
          chk(g, "write_pe1", longint'(pd1), longint'(w.d1));
          chk(g, "write_pe2", longint'(pd2), longint'(w.d2));
          last_a = w.addr; last_0 = w.d0; last_1 = w.d1; last_2 = w.d2;
        end
      end else begin
        if (expq.size() != 0 && expq[0].due <= cyc) begin
          chk(g, "missing_write", 0, 1);
          w = expq.pop_front();
        end
        chk(g, "addr_hold", longint'(preload_addr), longint'(last_a));
        chk(g, "pe0_hold", longint'(pd0), longint'(last_0));
        chk(g, "pe1_hold", longint'(pd1), longint'(last_1));
        chk(g, "pe2_hold", longint'(pd2), longint'(last_2));
      end
      chk(g, "s_ready", longint'(s_ready), longint'(exp_ready));
      chk(g, "busy", longint'(busy), longint'(exp_busy));
      chk(g, "done", longint'(done), longint'(exp_done));
      chk(g, "loaded_count", longint'(loaded_count), longint'(groups));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end

    task automatic idle_inputs();
      start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    endtask

    // Pulse start, then feed n words; returns at the negedge after the n-th acceptance
    task automatic stream(input int n, input int gap_pct, input bit rnd, input bit hold_start);
      int b = 0;
      int budget = 0;
      while (b < n && budget < 40 * n + 50) begin
        start   = (budget == 0) || hold_start;
        s_valid = (int'($urandom_range(99)) >= gap_pct);
        s_data  = rnd ? DW'($urandom) : DW'(b);
        @(negedge clk);
        if (s_valid && acc) b++;
        budget++;
      end
      chk(g, "stream_complete", longint'(b), longint'(n));
      s_valid = 1'b0;
      start   = 1'b0;
    endtask

    task automatic wait_done(input int d0);
      for (int i = 0; i < 8 && done_cnt == d0; i++) @(negedge clk);
      chk(g, "done_seen", longint'(done_cnt), longint'(d0 + 1));
    endtask

    bit fin_flag = 1'b0;

    initial begin : stim
      int t0, w0, d0, ab_n, rb;
      ab_n = (g == 0) ? 7 : 8;
      rb   = (g == 0) ? 20 : 5;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk(g, "reset_count", longint'(loaded_count), 0);
      chk(g, "reset_addr", longint'(preload_addr), 0);
      chk(g, "reset_en", longint'(preload_en), 0);
      rst = 1'b0;
      @(negedge clk);

      // Full-rate load with incrementing data
      t0 = cyc; w0 = wr_cnt; d0 = done_cnt;
      stream(NB, 0, 1'b0, 1'b0);
      wait_done(d0);
      chk(g, "full_done_latency", longint'(done_cyc - t0), longint'(NB + 2));
      chk(g, "full_writes", longint'(wr_cnt - w0), longint'(D));
      chk(g, "full_count", longint'(loaded_count), longint'(D));
      chk(g, "full_last_addr", longint'(preload_addr), longint'(D - 1));
      chk(g, "full_last_pe0", longint'(pd0), longint'(3 * (D - 1)));
      chk(g, "full_last_pe2", longint'(pd2), longint'(3 * (D - 1) + 2));

      // Source gaps: incrementing data, then random data
      for (int r = 0; r < 2; r++) begin
        @(negedge clk);
        w0 = wr_cnt; d0 = done_cnt;
        stream(NB, 50, r == 1, 1'b0);
        wait_done(d0);
        chk(g, "gap_writes", longint'(wr_cnt - w0), longint'(D));
        chk(g, "gap_count", longint'(loaded_count), longint'(D));
      end

      // Abort with a beat presented on the same cycle
      @(negedge clk);
      w0 = wr_cnt; d0 = done_cnt;
      stream(ab_n, 0, 1'b0, 1'b0);
      abort = 1'b1; s_valid = 1'b1; s_data = DW'(16'hBEEF);
      @(negedge clk);
      chk(g, "abort_ready_low", longint'(s_ready), 0);
      idle_inputs();
      repeat (4) @(negedge clk);
      chk(g, "abort_writes", longint'(wr_cnt - w0), 2);
      chk(g, "abort_no_done", longint'(done_cnt), longint'(d0));
      chk(g, "abort_count", longint'(loaded_count), 2);

      // Reload after abort starts from address 0
      w0 = wr_cnt; d0 = done_cnt;
      stream(NB, 25, 1'b1, 1'b0);
      wait_done(d0);
      chk(g, "reload_writes", longint'(wr_cnt - w0), longint'(D));

      // Reset in the middle of a load
      @(negedge clk);
      w0 = wr_cnt; d0 = done_cnt;
      stream(rb, 0, 1'b0, 1'b0);
      rst = 1'b1; s_valid = 1'b1;
      @(negedge clk);
      chk(g, "midrst_busy", longint'(busy), 0);
      chk(g, "midrst_count", longint'(loaded_count), 0);
      chk(g, "midrst_ready", longint'(s_ready), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      idle_inputs();
      chk(g, "midrst_writes", longint'(wr_cnt - w0), longint'(rb / 3));
      chk(g, "midrst_no_done", longint'(done_cnt), longint'(d0));

      // start held high through the load (incl. final beat), abort during FIN
      @(negedge clk);
      w0 = wr_cnt; d0 = done_cnt;
      stream(NB, 30, 1'b1, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(d0);
      repeat (5) @(negedge clk);
      chk(g, "boundary_single_done", longint'(done_cnt), longint'(d0 + 1));
      chk(g, "boundary_writes", longint'(wr_cnt - w0), longint'(D));
      chk(g, "boundary_count", longint'(loaded_count), longint'(D));
      chk(g, "boundary_idle", longint'(busy), 0);
      chk(g, "queue_empty", longint'(expq.size()), 0);
      fin_flag = 1'b1;
    end
  end

  initial begin : finish_ctl
    int t;
    t = 0;
    while (!(cfg[0].fin_flag && cfg[1].fin_flag) && t < 50000) begin
      @(negedge clk);
      t++;
    end
    if (!(cfg[0].fin_flag && cfg[1].fin_flag)) chk(-1, "timeout", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
